// File: rtl/lcd_pkg.sv
// Shared constants for the 4-bit character LCD controller: state codes, init tables,
// opcodes with long execution times, and default delays for a 50 MHz clock.
package lcd_pkg;

   localparam int unsigned CntW = 20;

   // Top FSM states
   localparam logic [3:0] StPwron    = 4'd0;
   localparam logic [3:0] StInitNib  = 4'd1;
   localparam logic [3:0] StInitWait = 4'd2;
   localparam logic [3:0] StIdle     = 4'd3;
   localparam logic [3:0] StLoad     = 4'd4;
   localparam logic [3:0] StNibHi    = 4'd5;
   localparam logic [3:0] StGap      = 4'd6;
   localparam logic [3:0] StNibLo    = 4'd7;
   localparam logic [3:0] StExec     = 4'd8;

   // Nibble strober states
   localparam logic [1:0] TxIdle  = 2'd0;
   localparam logic [1:0] TxSetup = 2'd1;
   localparam logic [1:0] TxHigh  = 2'd2;
   localparam logic [1:0] TxHold  = 2'd3;

   // Element [0] goes out first
   localparam logic [3:0][3:0] InitNibs  = {4'h2, 4'h3, 4'h3, 4'h3};
   localparam logic [3:0][7:0] InitBytes = {8'h01, 8'h0C, 8'h06, 8'h28};

   localparam logic [7:0] OpClear = 8'h01;
   localparam logic [7:0] OpHome  = 8'h02;

   localparam int unsigned DefTPwron     = 750000;
   localparam int unsigned DefTInitLong  = 205000;
   localparam int unsigned DefTInitShort = 5000;
   localparam int unsigned DefTESetup    = 2;
   localparam int unsigned DefTEHigh     = 12;
   localparam int unsigned DefTNibGap    = 50;
   localparam int unsigned DefTCmd       = 2000;
   localparam int unsigned DefTClear     = 82000;

endpackage

// File: rtl/lcd_nibble_tx.sv
// Drives one E-strobed nibble: setup with E low, E high pulse, one hold cycle.
// done_o is high during the hold cycle so the caller can chain without a dead cycle.
module lcd_nibble_tx
   import lcd_pkg::*;
#(
   parameter int unsigned TSetup = DefTESetup,
   parameter int unsigned THigh  = DefTEHigh
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic       rs_i,
   input  logic [3:0] nib_i,
   output logic       e_o,
   output logic       rs_o,
   output logic [3:0] d_o,
   output logic       done_o
);

   logic [1:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            e_q, e_d;
   logic            rs_q, rs_d;
   logic [3:0]      d_q, d_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      e_d     = e_q;
      rs_d    = rs_q;
      d_d     = d_q;
      case (state_q)
         TxIdle: begin
            if (start_i) begin
               state_d = TxSetup;
               cnt_d   = CntW'(TSetup - 1);
               rs_d    = rs_i;
               d_d     = nib_i;
            end
         end
         TxSetup: begin
            if (cnt_q == '0) begin
               state_d = TxHigh;
               e_d     = 1'b1;
               cnt_d   = CntW'(THigh - 1);
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         TxHigh: begin
            if (cnt_q == '0) begin
               state_d = TxHold;
               e_d     = 1'b0;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: state_d = TxIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= TxIdle;
         cnt_q   <= '0;
         e_q     <= 1'b0;
         rs_q    <= 1'b0;
         d_q     <= 4'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         e_q     <= e_d;
         rs_q    <= rs_d;
         d_q     <= d_d;
      end
   end

   assign e_o    = e_q;
   assign rs_o   = rs_q;
   assign d_o    = d_q;
   assign done_o = (state_q == TxHold);

endmodule

// File: rtl/lcd_nibble_ctrl.sv
// Character LCD 4-bit interface controller: power-on init, then byte writes over a
// valid/ready handshake with per-byte execution delay.
module lcd_nibble_ctrl
   import lcd_pkg::*;
#(
   parameter int unsigned T_PWRON      = DefTPwron,
   parameter int unsigned T_INIT_LONG  = DefTInitLong,
   parameter int unsigned T_INIT_SHORT = DefTInitShort,
   parameter int unsigned T_E_SETUP    = DefTESetup,
   parameter int unsigned T_E_HIGH     = DefTEHigh,
   parameter int unsigned T_NIB_GAP    = DefTNibGap,
   parameter int unsigned T_CMD        = DefTCmd,
   parameter int unsigned T_CLEAR      = DefTClear
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rs,
   input  logic [7:0] req_byte,
   output logic       init_done,
   output logic       sf_e,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [3:0] lcd_d
);

   logic [3:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      idx_q, idx_d;
   logic [7:0]      byte_q, byte_d;
   logic            rs_q, rs_d;
   logic            ready_q, ready_d;
   logic            init_done_q, init_done_d;

   logic            tx_start, tx_rs, tx_done;
   logic [3:0]      tx_nib;
   logic [1:0]      idx_inc;
   logic            cnt_zero, long_exec;
   logic [CntW-1:0] init_wait;

   assign idx_inc   = idx_q + 2'd1;
   assign cnt_zero  = (cnt_q == '0);
   assign long_exec = !rs_q && ((byte_q == OpClear) || (byte_q == OpHome));

   always_comb begin
      case (idx_q)
         2'd0:    init_wait = CntW'(T_INIT_LONG - 1);
         2'd1:    init_wait = CntW'(T_INIT_SHORT - 1);
         default: init_wait = CntW'(T_CMD - 1);
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_zero ? cnt_q : cnt_q - CntW'(1);
      idx_d       = idx_q;
      byte_d      = byte_q;
      rs_d        = rs_q;
      ready_d     = ready_q;
      init_done_d = init_done_q;
      tx_start    = 1'b0;
      tx_rs       = rs_q;
      tx_nib      = byte_q[7:4];
      unique case (state_q)
         StPwron: begin
            if (cnt_zero) begin
               tx_start = 1'b1;
               tx_rs    = 1'b0;
               tx_nib   = InitNibs[idx_q];
               state_d  = StInitNib;
            end
         end
         StInitNib: begin
            if (tx_done) begin
               cnt_d   = init_wait;
               state_d = StInitWait;
            end
         end
         StInitWait: begin
            if (cnt_zero) begin
               if (idx_q == 2'd3) begin
                  // Single nibbles done; the remaining init goes through the byte path
                  idx_d   = 2'd0;
                  byte_d  = InitBytes[0];
                  rs_d    = 1'b0;
                  state_d = StLoad;
               end else begin
                  idx_d    = idx_inc;
                  tx_start = 1'b1;
                  tx_rs    = 1'b0;
                  tx_nib   = InitNibs[idx_inc];
                  state_d  = StInitNib;
               end
            end
         end
         StIdle: begin
            if (req_valid && ready_q) begin
               byte_d  = req_byte;
               rs_d    = req_rs;
               ready_d = 1'b0;
               state_d = StLoad;
            end
         end
         StLoad: begin
            tx_start = 1'b1;
            state_d  = StNibHi;
         end
         StNibHi: begin
            if (tx_done) begin
               cnt_d   = CntW'(T_NIB_GAP - 1);
               state_d = StGap;
            end
         end
         StGap: begin
            if (cnt_zero) begin
               tx_start = 1'b1;
               tx_nib   = byte_q[3:0];
               state_d  = StNibLo;
            end
         end
         StNibLo: begin
            if (tx_done) begin
               cnt_d   = long_exec ? CntW'(T_CLEAR - 1) : CntW'(T_CMD - 1);
               state_d = StExec;
            end
         end
         StExec: begin
            if (cnt_zero) begin
               if (init_done_q || (idx_q == 2'd3)) begin
                  idx_d       = 2'd0;
                  init_done_d = 1'b1;
                  ready_d     = 1'b1;
                  state_d     = StIdle;
               end else begin
                  idx_d   = idx_inc;
                  byte_d  = InitBytes[idx_inc];
                  state_d = StLoad;
               end
            end
         end
         default: state_d = StPwron;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StPwron;
         cnt_q       <= CntW'(T_PWRON - 1);
         idx_q       <= 2'd0;
         byte_q      <= 8'h00;
         rs_q        <= 1'b0;
         ready_q     <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         byte_q      <= byte_d;
         rs_q        <= rs_d;
         ready_q     <= ready_d;
         init_done_q <= init_done_d;
      end
   end

   lcd_nibble_tx #(
      .TSetup (T_E_SETUP),
      .THigh  (T_E_HIGH)
   ) u_tx (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (tx_start),
      .rs_i    (tx_rs),
      .nib_i   (tx_nib),
      .e_o     (lcd_e),
      .rs_o    (lcd_rs),
      .d_o     (lcd_d),
      .done_o  (tx_done)
   );

   assign req_ready = ready_q;
   assign init_done = init_done_q;
   assign sf_e      = 1'b1;
   assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_nibble_ctrl.sv
// Directed bench for lcd_nibble_ctrl with small delays; records every E pulse and
// checks nibble values, pulse shape, handshake latency and reset behaviour.
module tb_lcd_nibble_ctrl;

   localparam int unsigned T_PWRON      = 20;
   localparam int unsigned T_INIT_LONG  = 15;
   localparam int unsigned T_INIT_SHORT = 8;
   localparam int unsigned T_E_SETUP    = 2;
   localparam int unsigned T_E_HIGH     = 4;
   localparam int unsigned T_NIB_GAP    = 3;
   localparam int unsigned T_CMD        = 10;
   localparam int unsigned T_CLEAR      = 30;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_rs = 1'b0;
   logic [7:0] req_byte = 8'h00;
   logic       init_done;
   logic       sf_e, lcd_e, lcd_rs, lcd_rw;
   logic [3:0] lcd_d;

   lcd_nibble_ctrl #(
      .T_PWRON      (T_PWRON),
      .T_INIT_LONG  (T_INIT_LONG),
      .T_INIT_SHORT (T_INIT_SHORT),
      .T_E_SETUP    (T_E_SETUP),
      .T_E_HIGH     (T_E_HIGH),
      .T_NIB_GAP    (T_NIB_GAP),
      .T_CMD        (T_CMD),
      .T_CLEAR      (T_CLEAR)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rs    (req_rs),
      .req_byte  (req_byte),
      .init_done (init_done),
      .sf_e      (sf_e),
      .lcd_e     (lcd_e),
      .lcd_rs    (lcd_rs),
      .lcd_rw    (lcd_rw),
      .lcd_d     (lcd_d)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // E pulse recorder
   typedef struct {
      int  nib;
      int  rs;
      int  width;
      int  rise;
      int  fall;
      bit  setup_ok;
      bit  stable_ok;
   } pulse_t;

   pulse_t     pq[$];
   pulse_t     cur;
   bit         in_p = 1'b0;
   bit         const_bad = 1'b0;
   int         stab = 0;
   logic [4:0] prev_v = 5'h0;

   always @(negedge clk) begin
      if (sf_e !== 1'b1 || lcd_rw !== 1'b0) const_bad = 1'b1;
      if (rst) begin
         in_p = 1'b0;
         stab = 0;
      end else begin
         if ({lcd_d, lcd_rs} == prev_v) stab++;
         else stab = 1;
         if (lcd_e && !in_p) begin
            in_p          = 1'b1;
            cur.nib       = int'(lcd_d);
            cur.rs        = int'(lcd_rs);
            cur.width     = 1;
            cur.rise      = cyc;
            cur.setup_ok  = (stab >= int'(T_E_SETUP) + 1);
            cur.stable_ok = 1'b1;
         end else if (lcd_e && in_p) begin
            cur.width++;
            if (int'(lcd_d) != cur.nib || int'(lcd_rs) != cur.rs) cur.stable_ok = 1'b0;
         end else if (!lcd_e && in_p) begin
            in_p = 1'b0;
            if (int'(lcd_d) != cur.nib || int'(lcd_rs) != cur.rs) cur.stable_ok = 1'b0;
            cur.fall = cyc;
            pq.push_back(cur);
         end
      end
      prev_v = {lcd_d, lcd_rs};
   end

   task automatic check_pulse(input string tag, input int i, input int nib, input int rs);
      check($sformatf("%s_p%0d_nib", tag, i), pq[i].nib, nib);
      check($sformatf("%s_p%0d_rs", tag, i), pq[i].rs, rs);
      check($sformatf("%s_p%0d_width", tag, i), pq[i].width, int'(T_E_HIGH));
      check($sformatf("%s_p%0d_setup", tag, i), int'(pq[i].setup_ok), 1);
      check($sformatf("%s_p%0d_hold", tag, i), int'(pq[i].stable_ok), 1);
   endtask

   task automatic wait_ready(input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (req_ready) begin
            at = cyc;
            break;
         end
      end
   endtask

   // Waits for init_done after reset release at cycle rel and checks the full init sequence
   task automatic check_init(input string tag, input int rel);
      int d;
      int exp_nibs [12];
      exp_nibs = '{3, 3, 3, 2, 2, 8, 0, 6, 0, 12, 0, 1};
      d = -1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (init_done) begin
            d = cyc;
            break;
         end
      end
      check({tag, "_done_seen"}, int'(d >= 0), 1);
      check({tag, "_ready_with_done"}, int'(req_ready), 1);
      check({tag, "_pulse_count"}, pq.size(), 12);
      if (pq.size() == 12) begin
         for (int i = 0; i < 12; i++) check_pulse(tag, i, exp_nibs[i], 0);
         check({tag, "_first_rise"}, pq[0].rise - rel, int'(T_PWRON + T_E_SETUP));
         check({tag, "_done_after_fall"}, d - pq[11].fall, int'(T_CLEAR) + 1);
      end
   endtask

   task automatic send(input logic rs, input logic [7:0] b, output int acc);
      int rdy;
      wait_ready(300, rdy);
      check("send_ready_seen", int'(rdy >= 0), 1);
      req_valid = 1'b1;
      req_rs    = rs;
      req_byte  = b;
      @(negedge clk);
      acc = cyc;
      check("send_ready_drop", int'(req_ready), 0);
      // Busy-time input changes must not reach the bus
      req_valid = 1'b0;
      req_rs    = ~rs;
      req_byte  = ~b;
   endtask

   typedef struct {
      logic       rs;
      logic [7:0] b;
      int         hi;
      int         lo;
      int         lat;
   } vec_t;

   vec_t vecs [6];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, rdy, a1, a2, rel;

      vecs[0] = '{1'b1, 8'h41, 4'h4, 4'h1, 28};
      vecs[1] = '{1'b0, 8'h01, 4'h0, 4'h1, 48};
      vecs[2] = '{1'b0, 8'h80, 4'h8, 4'h0, 28};
      vecs[3] = '{1'b0, 8'h02, 4'h0, 4'h2, 48};
      vecs[4] = '{1'b1, 8'h01, 4'h0, 4'h1, 28};
      vecs[5] = '{1'b1, 8'hA7, 4'hA, 4'h7, 28};

      #3 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_lcd_e", int'(lcd_e), 0);
      check("rst_lcd_rs", int'(lcd_rs), 0);
      check("rst_lcd_d", int'(lcd_d), 0);
      check("rst_lcd_rw", int'(lcd_rw), 0);
      check("rst_sf_e", int'(sf_e), 1);
      check("rst_req_ready", int'(req_ready), 0);
      check("rst_init_done", int'(init_done), 0);

      // Request pending throughout init: must not be taken early
      req_valid = 1'b1;
      req_rs    = 1'b1;
      req_byte  = 8'h55;
      rst       = 1'b0;
      rel       = cyc;
      check_init("init1", rel);
      @(negedge clk);
      acc = cyc;
      check("preinit_accept_first", int'(req_ready), 0);
      req_valid = 1'b0;
      wait_ready(300, rdy);
      check("preinit_latency", rdy - acc, 28);
      check("preinit_pulse_count", pq.size(), 14);
      if (pq.size() == 14) begin
         check_pulse("preinit", 12, 5, 1);
         check_pulse("preinit", 13, 5, 1);
         check("preinit_first_rise", pq[12].rise - acc, 1 + int'(T_E_SETUP));
      end

      for (int v = 0; v < 6; v++) begin
         pq.delete();
         send(vecs[v].rs, vecs[v].b, acc);
         wait_ready(300, rdy);
         check($sformatf("vec%0d_latency", v), rdy - acc, vecs[v].lat);
         check($sformatf("vec%0d_pulse_count", v), pq.size(), 2);
         if (pq.size() == 2) begin
            check_pulse($sformatf("vec%0d", v), 0, vecs[v].hi, int'(vecs[v].rs));
            check_pulse($sformatf("vec%0d", v), 1, vecs[v].lo, int'(vecs[v].rs));
            check($sformatf("vec%0d_first_rise", v), pq[0].rise - acc, 1 + int'(T_E_SETUP));
         end
      end

      // Back-to-back with req_valid held high
      pq.delete();
      wait_ready(300, rdy);
      req_valid = 1'b1;
      req_rs    = 1'b0;
      req_byte  = 8'h33;
      @(negedge clk);
      a1 = cyc;
      check("b2b_first_accept", int'(req_ready), 0);
      req_rs   = 1'b1;
      req_byte = 8'hC5;
      wait_ready(300, rdy);
      check("b2b_ready_return", rdy - a1, 28);
      @(negedge clk);
      a2 = cyc;
      check("b2b_second_accept", int'(req_ready), 0);
      req_valid = 1'b0;
      check("b2b_period", a2 - a1, 29);
      wait_ready(300, rdy);
      check("b2b_pulse_count", pq.size(), 4);
      if (pq.size() == 4) begin
         check_pulse("b2b", 0, 3, 0);
         check_pulse("b2b", 1, 3, 0);
         check_pulse("b2b", 2, 12, 1);
         check_pulse("b2b", 3, 5, 1);
      end
      repeat (5) @(negedge clk);
      check("b2b_no_extra", pq.size(), 4);

      // Reset while E is high
      send(1'b1, 8'h7E, acc);
      rdy = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (lcd_e) begin
            rdy = cyc;
            break;
         end
      end
      check("abort_e_seen", int'(rdy >= 0), 1);
      #2 rst = 1'b1;
      #1;
      check("abort_lcd_e", int'(lcd_e), 0);
      check("abort_init_done", int'(init_done), 0);
      check("abort_req_ready", int'(req_ready), 0);
      repeat (2) @(negedge clk);
      pq.delete();
      rst = 1'b0;
      rel = cyc;
      check_init("init2", rel);

      check("sf_e_rw_const", int'(const_bad), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
